// File: rtl/sw_pkg.sv
// Shared aligner base-stream definitions.
// Base codes, ASCII framing bytes and the streamer FSM states.
package sw_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_G = 2'b01,
    BASE_T = 2'b10,
    BASE_C = 2'b11
  } base_t;

  localparam logic [7:0] GT = 8'h3E;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic [2:0] {
    S_IDLE,
    S_Q_HDR,
    S_Q_SEQ,
    S_DB_WAIT,
    S_DB_HDR,
    S_DB_SEQ,
    S_GAP
  } state_t;

  // Returns {ok, base}; ok=0 for anything that is not ACGT/acgt.
  function automatic logic [2:0] to_base(input logic [7:0] ch);
    case (ch)
      8'h41, 8'h61: return {1'b1, BASE_A};
      8'h47, 8'h67: return {1'b1, BASE_G};
      8'h54, 8'h74: return {1'b1, BASE_T};
      8'h43, 8'h63: return {1'b1, BASE_C};
      default:      return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sw_base_encoder.sv
// ASCII nucleotide to 2-bit base code.
// Purely combinational; ok flags a valid ACGT byte.
module sw_base_encoder
  import sw_pkg::*;
(
  input  logic [7:0] ch,
  output logic       ok,
  output base_t      code
);

  logic [2:0] r;

  assign r    = to_base(ch);
  assign ok   = r[2];
  assign code = base_t'(r[1:0]);

endmodule

// File: rtl/sw_fasta_streamer.sv
// FASTA byte parser: first record packed as the query,
// later records streamed one base per cycle with framing.
module sw_fasta_streamer
  import sw_pkg::*;
#(
  parameter int MAX_QUERY_LEN = 50,
  parameter int LEN_W         = 7,
  parameter int GAP_CYCLES    = 1,
  parameter int IDX_W         = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_char_vld,
  input  logic [7:0]                 i_char,
  output logic                       o_char_rdy,
  output logic [2*MAX_QUERY_LEN-1:0] o_query,
  output logic [LEN_W-1:0]           o_query_length,
  output logic                       o_query_vld,
  output logic                       o_vld,
  output logic [1:0]                 o_data,
  output logic                       o_seq_start,
  output logic                       o_seq_end,
  output logic [IDX_W-1:0]           o_seq_idx,
  output logic                       o_err_char,
  output logic                       o_err_qlen
);

  localparam int CNT_W = $clog2(MAX_QUERY_LEN + 1);
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  state_t           state, nxt;
  logic             take, is_lf, is_cr, is_gt;
  logic             ok;
  base_t            code;
  logic             first;
  logic [CNT_W-1:0] qcnt;
  logic [GW-1:0]    gcnt;

  sw_base_encoder u_enc (
    .ch   (i_char),
    .ok   (ok),
    .code (code)
  );

  assign o_char_rdy = (state != S_GAP);
  assign take  = i_char_vld & o_char_rdy;
  assign is_lf = (i_char == LF);
  assign is_cr = (i_char == CR);
  assign is_gt = (i_char == GT);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (take && is_gt) nxt = S_Q_HDR;
      S_Q_HDR:   if (take && is_lf) nxt = S_Q_SEQ;
      S_Q_SEQ:
        if (take && is_lf)
          nxt = (qcnt == '0) ? S_IDLE : S_DB_WAIT;
      S_DB_WAIT: if (take && is_gt) nxt = S_DB_HDR;
      S_DB_HDR:  if (take && is_lf) nxt = S_DB_SEQ;
      S_DB_SEQ:  if (take && is_lf) nxt = S_GAP;
      S_GAP:     if (gcnt == '0)    nxt = S_DB_WAIT;
      default:   nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_query        <= '0;
      o_query_length <= '0;
      o_query_vld    <= 1'b0;
      o_vld          <= 1'b0;
      o_data         <= '0;
      o_seq_start    <= 1'b0;
      o_seq_end      <= 1'b0;
      o_seq_idx      <= '0;
      o_err_char     <= 1'b0;
      o_err_qlen     <= 1'b0;
      first          <= 1'b0;
      qcnt           <= '0;
      gcnt           <= '0;
    end else begin
      o_vld       <= 1'b0;
      o_seq_start <= 1'b0;
      o_seq_end   <= 1'b0;
      case (state)
        S_Q_SEQ: begin
          if (take && is_lf) begin
            if (qcnt == '0) begin
              o_err_qlen <= 1'b1;
            end else begin
              o_query_length <= LEN_W'(qcnt - CNT_W'(1));
              o_query_vld    <= 1'b1;
            end
          end else if (take && !is_cr) begin
            if (!ok) begin
              o_err_char <= 1'b1;
            end else if (qcnt == CNT_W'(MAX_QUERY_LEN)) begin
              o_err_qlen <= 1'b1;
            end else begin
              for (int i = 0; i < MAX_QUERY_LEN; i++)
                if (qcnt == CNT_W'(i))
                  o_query[2*i +: 2] <= code;
              qcnt <= qcnt + CNT_W'(1);
            end
          end
        end
        S_DB_HDR: begin
          if (take && is_lf) first <= 1'b1;
        end
        S_DB_SEQ: begin
          if (take && is_lf) begin
            o_seq_end <= 1'b1;
            first     <= 1'b0;
            gcnt      <= GW'(GAP_CYCLES - 1);
          end else if (take && !is_cr) begin
            if (ok) begin
              o_vld       <= 1'b1;
              o_data      <= code;
              o_seq_start <= first;
              first       <= 1'b0;
            end else begin
              o_err_char <= 1'b1;
            end
          end
        end
        S_GAP: begin
          // Record index advances only once the gap is over.
          if (gcnt == '0) o_seq_idx <= o_seq_idx + IDX_W'(1);
          else            gcnt      <= gcnt - GW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_fasta_streamer.sv
// Directed bench for sw_fasta_streamer.
// Byte driver plus negedge monitor of stream and framing.
module tb_sw_fasta_streamer;
  import sw_pkg::*;

  localparam int MQ = 50;
  localparam int LW = 7;
  localparam int GC = 3;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_char_vld;
  logic [7:0]      i_char;
  logic            o_char_rdy;
  logic [2*MQ-1:0] o_query;
  logic [LW-1:0]   o_query_length;
  logic            o_query_vld;
  logic            o_vld;
  logic [1:0]      o_data;
  logic            o_seq_start;
  logic            o_seq_end;
  logic [IW-1:0]   o_seq_idx;
  logic            o_err_char;
  logic            o_err_qlen;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int run = 0;

  int dq[$];
  int dc[$];
  int sc[$];
  int ec[$];
  int sidx[$];
  int eidx[$];
  int runs[$];

  sw_fasta_streamer #(
    .MAX_QUERY_LEN (MQ),
    .LEN_W         (LW),
    .GAP_CYCLES    (GC),
    .IDX_W         (IW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_char_vld     (i_char_vld),
    .i_char         (i_char),
    .o_char_rdy     (o_char_rdy),
    .o_query        (o_query),
    .o_query_length (o_query_length),
    .o_query_vld    (o_query_vld),
    .o_vld          (o_vld),
    .o_data         (o_data),
    .o_seq_start    (o_seq_start),
    .o_seq_end      (o_seq_end),
    .o_seq_idx      (o_seq_idx),
    .o_err_char     (o_err_char),
    .o_err_qlen     (o_err_qlen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_vld) begin
      dq.push_back(int'(o_data));
      dc.push_back(cyc);
    end
    if (o_seq_start) begin
      sc.push_back(cyc);
      sidx.push_back(int'(o_seq_idx));
    end
    if (o_seq_end) begin
      ec.push_back(cyc);
      eidx.push_back(int'(o_seq_idx));
    end
    if (!o_char_rdy) begin
      run = run + 1;
    end else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    i_char_vld = 1'b1;
    i_char = b;
    while (!o_char_rdy && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 100) begin
      tests++;
      fails++;
      $display("FAIL send_timeout byte=%h", b);
    end
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(input int n);
    i_char_vld = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    i_char_vld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_char_vld = 1'b0;
    i_char = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (o_query !== '0 || o_query_length !== '0 || o_query_vld !== 1'b0) begin
      fails++;
      $display("FAIL reset_query got q=%h len=%0d vld=%b want 0",
               o_query, o_query_length, o_query_vld);
    end
    tests++;
    if (o_vld !== 1'b0 || o_seq_start !== 1'b0 || o_seq_end !== 1'b0 ||
        o_seq_idx !== '0 || o_data !== 2'b00) begin
      fails++;
      $display("FAIL reset_stream got vld=%b st=%b en=%b idx=%0d d=%b want 0",
               o_vld, o_seq_start, o_seq_end, o_seq_idx, o_data);
    end
    tests++;
    if (o_err_char !== 1'b0 || o_err_qlen !== 1'b0) begin
      fails++;
      $display("FAIL reset_err got %b%b want 00", o_err_char, o_err_qlen);
    end
    rst = 1'b0;
  endtask

  task automatic test_query();
    send_str(">q\nACGT");
    tests++;
    if (o_query_vld !== 1'b0) begin
      fails++;
      $display("FAIL query_vld_early got %b want 0", o_query_vld);
    end
    send(LF);
    i_char_vld = 1'b0;
    tests++;
    if (o_query_vld !== 1'b1) begin
      fails++;
      $display("FAIL query_vld got %b want 1", o_query_vld);
    end
    tests++;
    if (o_query !== {{(2*MQ-8){1'b0}}, 8'h9C}) begin
      fails++;
      $display("FAIL query_bits got %h want 9c", o_query);
    end
    tests++;
    if (o_query_length !== LW'(3)) begin
      fails++;
      $display("FAIL query_len got %0d want 3", o_query_length);
    end
  endtask

  task automatic test_db();
    int b, s, e;
    int exp7[7] = '{1, 0, 2, 2, 0, 3, 0};
    b = dq.size();
    s = sc.size();
    e = ec.size();
    send_str(">d\ngattaca\n");
    idle(6);
    tests++;
    if (dq.size() - b != 7) begin
      fails++;
      $display("FAIL db_count got %0d want 7", dq.size() - b);
    end else begin
      for (int i = 0; i < 7; i++) begin
        tests++;
        if (dq[b+i] != exp7[i]) begin
          fails++;
          $display("FAIL db_data[%0d] got %0d want %0d", i, dq[b+i], exp7[i]);
        end
      end
      tests++;
      if (dc[b+6] - dc[b] != 6) begin
        fails++;
        $display("FAIL db_consec got span %0d want 6", dc[b+6] - dc[b]);
      end
      tests++;
      if (sc.size() - s != 1 || ec.size() - e != 1) begin
        fails++;
        $display("FAIL db_frames got st=%0d en=%0d want 1 1",
                 sc.size() - s, ec.size() - e);
      end else begin
        tests++;
        if (sc[s] != dc[b] || ec[e] != dc[b+6] + 1) begin
          fails++;
          $display("FAIL db_frame_time got st=%0d en=%0d want %0d %0d",
                   sc[s], ec[e], dc[b], dc[b+6] + 1);
        end
        tests++;
        if (sidx[s] != 0 || eidx[e] != 0) begin
          fails++;
          $display("FAIL db_idx got %0d %0d want 0 0", sidx[s], eidx[e]);
        end
      end
    end
    send_str(">e\nAC\n");
    idle(6);
    tests++;
    if (sc.size() - s != 2) begin
      fails++;
      $display("FAIL db2_start got %0d want 2", sc.size() - s);
    end else if (sidx[s+1] != 1) begin
      fails++;
      $display("FAIL db2_idx got %0d want 1", sidx[s+1]);
    end
  endtask

  task automatic test_back_to_back();
    int b, s, r;
    int exp4[4] = '{0, 1, 2, 2};
    b = dq.size();
    s = sc.size();
    r = runs.size();
    send_str(">a\nAG\n>b\nTT\n");
    idle(8);
    tests++;
    if (runs.size() - r != 2) begin
      fails++;
      $display("FAIL b2b_runs got %0d want 2", runs.size() - r);
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (runs[r+i] != GC) begin
          fails++;
          $display("FAIL b2b_gap[%0d] got %0d want %0d", i, runs[r+i], GC);
        end
      end
    end
    tests++;
    if (dq.size() - b != 4) begin
      fails++;
      $display("FAIL b2b_count got %0d want 4", dq.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (dq[b+i] != exp4[i]) begin
          fails++;
          $display("FAIL b2b_data[%0d] got %0d want %0d", i, dq[b+i], exp4[i]);
        end
      end
    end
    tests++;
    if (sc.size() - s != 2) begin
      fails++;
      $display("FAIL b2b_starts got %0d want 2", sc.size() - s);
    end else if (sidx[s] != 2 || sidx[s+1] != 3) begin
      fails++;
      $display("FAIL b2b_idx got %0d %0d want 2 3", sidx[s], sidx[s+1]);
    end
  endtask

  task automatic test_err_char();
    int b, s, e;
    b = dq.size();
    s = sc.size();
    e = ec.size();
    tests++;
    if (o_err_char !== 1'b0) begin
      fails++;
      $display("FAIL errc_pre got %b want 0", o_err_char);
    end
    send_str(">x\nAXC\r\n");
    idle(6);
    tests++;
    if (dq.size() - b != 2) begin
      fails++;
      $display("FAIL errc_count got %0d want 2", dq.size() - b);
    end else if (dq[b] != 0 || dq[b+1] != 3) begin
      fails++;
      $display("FAIL errc_data got %0d %0d want 0 3", dq[b], dq[b+1]);
    end
    tests++;
    if (o_err_char !== 1'b1) begin
      fails++;
      $display("FAIL errc_flag got %b want 1", o_err_char);
    end
    tests++;
    if (sc.size() - s != 1 || ec.size() - e != 1) begin
      fails++;
      $display("FAIL errc_frames got %0d %0d want 1 1",
               sc.size() - s, ec.size() - e);
    end
  endtask

  task automatic test_rst_mid();
    send_str(">d\nAC");
    idle(1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (o_query !== '0 || o_query_length !== '0 || o_query_vld !== 1'b0 ||
        o_vld !== 1'b0 || o_seq_start !== 1'b0 || o_seq_end !== 1'b0 ||
        o_seq_idx !== '0 || o_err_char !== 1'b0 || o_err_qlen !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid got q=%h len=%0d qv=%b v=%b idx=%0d ec=%b eq=%b want 0",
               o_query, o_query_length, o_query_vld, o_vld,
               o_seq_idx, o_err_char, o_err_qlen);
    end
    send_str(">q\nAC\n");
    i_char_vld = 1'b0;
    tests++;
    if (o_query_vld !== 1'b1 || o_query_length !== LW'(1)) begin
      fails++;
      $display("FAIL rst_requery got vld=%b len=%0d want 1 1",
               o_query_vld, o_query_length);
    end
    tests++;
    if (o_query !== {{(2*MQ-4){1'b0}}, 4'hC}) begin
      fails++;
      $display("FAIL rst_requery_bits got %h want c", o_query);
    end
  endtask

  task automatic test_qlen();
    string pat;
    int code[4] = '{0, 3, 1, 2};
    logic [2*MQ-1:0] exp;
    int b;
    pat = "ACGT";
    exp = '0;
    for (int i = 0; i < MQ; i++) exp[2*i +: 2] = 2'(code[i % 4]);
    do_rst();
    send_str(">q\n");
    for (int i = 0; i < MQ; i++) send(pat[i % 4]);
    tests++;
    if (o_err_qlen !== 1'b0) begin
      fails++;
      $display("FAIL qlen_at_max got %b want 0", o_err_qlen);
    end
    send(pat[0]);
    send(pat[1]);
    send(LF);
    i_char_vld = 1'b0;
    tests++;
    if (o_err_qlen !== 1'b1) begin
      fails++;
      $display("FAIL qlen_flag got %b want 1", o_err_qlen);
    end
    tests++;
    if (o_query_length !== LW'(MQ - 1) || o_query_vld !== 1'b1) begin
      fails++;
      $display("FAIL qlen_len got %0d vld=%b want %0d 1",
               o_query_length, o_query_vld, MQ - 1);
    end
    tests++;
    if (o_query !== exp) begin
      fails++;
      $display("FAIL qlen_bits got %h want %h", o_query, exp);
    end
    b = dq.size();
    send_str(">d\nCA\n");
    idle(6);
    tests++;
    if (dq.size() - b != 2) begin
      fails++;
      $display("FAIL qlen_db_count got %0d want 2", dq.size() - b);
    end else if (dq[b] != 3 || dq[b+1] != 0) begin
      fails++;
      $display("FAIL qlen_db_data got %0d %0d want 3 0", dq[b], dq[b+1]);
    end
  endtask

  task automatic test_empty_query();
    do_rst();
    send_str(">q\n\n");
    idle(2);
    tests++;
    if (o_query_vld !== 1'b0 || o_err_qlen !== 1'b1) begin
      fails++;
      $display("FAIL empty_q got vld=%b err=%b want 0 1",
               o_query_vld, o_err_qlen);
    end
    send_str(">q\nG\n");
    i_char_vld = 1'b0;
    tests++;
    if (o_query_vld !== 1'b1 || o_query_length !== '0 ||
        o_query !== {{(2*MQ-2){1'b0}}, 2'b01}) begin
      fails++;
      $display("FAIL empty_requery got vld=%b len=%0d q=%h want 1 0 1",
               o_query_vld, o_query_length, o_query);
    end
  endtask

  initial begin
    test_reset();
    test_query();
    test_db();
    test_back_to_back();
    test_err_char();
    test_rst_mid();
    test_qlen();
    test_empty_query();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
